// File: rtl/multicycle_cpu_core.sv
// Multicycle TSC-ISA core with memory ready handshake, watchdog, single-step and fault halt.
// ALU and four-entry register file are folded in as plain combinational/state logic.
module multicycle_cpu_core #(
    parameter int unsigned            WORD_SIZE = 16,
    parameter logic [WORD_SIZE-1:0]   RESET_PC  = 16'h0000,
    parameter int unsigned            TIMEOUT   = 255,
    parameter int unsigned            TIMEOUT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic                 readM,
    output logic                 writeM,
    output logic [WORD_SIZE-1:0] address,
    inout  wire  [WORD_SIZE-1:0] data,
    input  logic                 mem_ready,
    input  logic                 step_mode,
    input  logic                 step,
    output logic [WORD_SIZE-1:0] num_inst,
    output logic [WORD_SIZE-1:0] output_port,
    output logic                 is_halted,
    output logic                 fault
);

    typedef enum logic [2:0] {
        StFetch, StDecode, StExec, StMem, StWb, StStepWait, StHalt, StFault
    } state_e;

    localparam logic [3:0] OpBne = 4'd0,  OpBeq = 4'd1, OpBgz = 4'd2, OpBlz = 4'd3;
    localparam logic [3:0] OpAdi = 4'd4,  OpOri = 4'd5, OpLhi = 4'd6, OpLwd = 4'd7;
    localparam logic [3:0] OpSwd = 4'd8,  OpJmp = 4'd9, OpJal = 4'd10, OpR  = 4'd15;
    localparam logic [5:0] FnJpr = 6'd25, FnJrl = 6'd26, FnWwd = 6'd28, FnHlt = 6'd29;

    state_e                 state_q, state_d;
    logic [WORD_SIZE-1:0]   pc_q, pc_d, ir_q, ir_d, alu_q, alu_d, mdr_q, mdr_d;
    logic [WORD_SIZE-1:0]   num_q, num_d, out_q, out_d;
    logic [WORD_SIZE-1:0]   regs_q [4];
    logic [WORD_SIZE-1:0]   regs_d [4];
    logic [TIMEOUT_W-1:0]   wait_q, wait_d;
    logic                   started_q;

    logic [3:0]             op;
    logic [5:0]             func;
    logic [1:0]             rs_idx, rt_idx, rd_idx;
    logic [WORD_SIZE-1:0]   rs_val, rt_val, imm_sext, alu_res;
    logic                   legal, taken, retire, req_active;

    assign op       = ir_q[15:12];
    assign rs_idx   = ir_q[11:10];
    assign rt_idx   = ir_q[9:8];
    assign rd_idx   = ir_q[7:6];
    assign func     = ir_q[5:0];
    assign rs_val   = regs_q[rs_idx];
    assign rt_val   = regs_q[rt_idx];
    assign imm_sext = {{(WORD_SIZE-8){ir_q[7]}}, ir_q[7:0]};

    assign legal = (op <= OpJal) ||
                   (op == OpR && (func <= 6'd7 || func == FnJpr || func == FnJrl ||
                                  func == FnWwd || func == FnHlt));

    always_comb begin
        taken = 1'b0;
        unique case (op)
            OpBne:   taken = (rs_val != rt_val);
            OpBeq:   taken = (rs_val == rt_val);
            OpBgz:   taken = !rs_val[WORD_SIZE-1] && (rs_val != '0);
            OpBlz:   taken = rs_val[WORD_SIZE-1];
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        alu_res = '0;
        unique case (op)
            OpAdi: alu_res = rs_val + imm_sext;
            OpOri: alu_res = rs_val | {{(WORD_SIZE-8){1'b0}}, ir_q[7:0]};
            OpLhi: alu_res = {ir_q[7:0], 8'h00};
            OpR: begin
                unique case (func)
                    6'd0:    alu_res = rs_val + rt_val;
                    6'd1:    alu_res = rs_val - rt_val;
                    6'd2:    alu_res = rs_val & rt_val;
                    6'd3:    alu_res = rs_val | rt_val;
                    6'd4:    alu_res = ~rs_val;
                    6'd5:    alu_res = ~rs_val + 1'b1;
                    6'd6:    alu_res = {rs_val[WORD_SIZE-2:0], 1'b0};
                    6'd7:    alu_res = {rs_val[WORD_SIZE-1], rs_val[WORD_SIZE-1:1]};
                    default: alu_res = '0;
                endcase
            end
            default: alu_res = '0;
        endcase
    end

    // Fetch waits one edge after reset so readM never rises asynchronously.
    assign readM      = (state_q == StFetch && started_q) || (state_q == StMem && op == OpLwd);
    assign writeM     = (state_q == StMem && op == OpSwd);
    assign req_active = readM || writeM;
    assign address    = (state_q == StMem) ? alu_q : pc_q;
    assign data       = writeM ? rt_val : {WORD_SIZE{1'bz}};

    assign num_inst    = num_q;
    assign output_port = out_q;
    assign is_halted   = (state_q == StHalt);
    assign fault       = (state_q == StFault);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        alu_d   = alu_q;
        mdr_d   = mdr_q;
        num_d   = num_q;
        out_d   = out_q;
        wait_d  = wait_q;
        regs_d  = regs_q;
        retire  = 1'b0;
        unique case (state_q)
            StFetch: begin
                if (started_q && mem_ready) begin
                    ir_d    = data;
                    pc_d    = pc_q + 1'b1;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                alu_d   = pc_q + imm_sext;
                state_d = legal ? StExec : StFault;
            end
            StExec: begin
                unique case (op)
                    OpBne, OpBeq, OpBgz, OpBlz: begin
                        if (taken) pc_d = alu_q;
                        retire = 1'b1;
                    end
                    OpJmp, OpJal: begin
                        pc_d = {pc_q[WORD_SIZE-1:12], ir_q[11:0]};
                        if (op == OpJal) regs_d[2] = pc_q;
                        retire = 1'b1;
                    end
                    OpLwd, OpSwd: begin
                        alu_d   = rs_val + imm_sext;
                        state_d = StMem;
                    end
                    OpR: begin
                        unique case (func)
                            FnJpr: begin pc_d = rs_val; retire = 1'b1; end
                            FnJrl: begin pc_d = rs_val; regs_d[2] = pc_q; retire = 1'b1; end
                            FnWwd: begin out_d = rs_val; retire = 1'b1; end
                            FnHlt: begin num_d = num_q + 1'b1; state_d = StHalt; end
                            default: begin alu_d = alu_res; state_d = StWb; end
                        endcase
                    end
                    default: begin
                        alu_d   = alu_res;
                        state_d = StWb;
                    end
                endcase
            end
            StMem: begin
                if (mem_ready) begin
                    if (op == OpLwd) begin
                        mdr_d   = data;
                        state_d = StWb;
                    end else begin
                        retire = 1'b1;
                    end
                end
            end
            StWb: begin
                regs_d[(op == OpR) ? rd_idx : rt_idx] = (op == OpLwd) ? mdr_q : alu_q;
                retire = 1'b1;
            end
            StStepWait: begin
                if (step || !step_mode) state_d = StFetch;
            end
            StHalt, StFault: ;
            default: state_d = StFault;
        endcase
        if (retire) begin
            num_d   = num_q + 1'b1;
            state_d = step_mode ? StStepWait : StFetch;
        end
        // Watchdog: a completion on the last allowed cycle beats the timeout.
        if (req_active) begin
            if (mem_ready) begin
                wait_d = '0;
            end else if (wait_q == TIMEOUT_W'(TIMEOUT - 1)) begin
                wait_d  = '0;
                state_d = StFault;
            end else begin
                wait_d = wait_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StFetch;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            alu_q     <= '0;
            mdr_q     <= '0;
            num_q     <= '0;
            out_q     <= '0;
            wait_q    <= '0;
            regs_q    <= '{default: '0};
            started_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            alu_q     <= alu_d;
            mdr_q     <= mdr_d;
            num_q     <= num_d;
            out_q     <= out_d;
            wait_q    <= wait_d;
            regs_q    <= regs_d;
            started_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_multicycle_cpu_core.sv
// Directed bench for multicycle_cpu_core: wait states, store/load/branch, watchdog,
// illegal opcode, single-step and asynchronous reset during a load.
module tb_multicycle_cpu_core;

    logic        clk, reset, step_mode, step;
    logic        readM, writeM, is_halted, fault, mem_ready;
    logic [15:0] address, num_inst, output_port;
    wire  [15:0] data;

    logic [15:0] mem [0:255];
    logic [15:0] rd_word, wr_addr, wr_data;
    logic [7:0]  req_age, wait_n;
    logic [7:0]  wr_cnt;
    logic        force_low;
    int          checks, errors;

    multicycle_cpu_core #(
        .WORD_SIZE (16),
        .RESET_PC  (16'h0000),
        .TIMEOUT   (4),
        .TIMEOUT_W (3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .readM       (readM),
        .writeM      (writeM),
        .address     (address),
        .data        (data),
        .mem_ready   (mem_ready),
        .step_mode   (step_mode),
        .step        (step),
        .num_inst    (num_inst),
        .output_port (output_port),
        .is_halted   (is_halted),
        .fault       (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: program array plus a one-entry write overlay for stores.
    assign rd_word   = (wr_cnt != 8'd0 && address == wr_addr) ? wr_data : mem[address[7:0]];
    assign data      = (readM && !writeM) ? rd_word : 16'hzzzz;
    assign mem_ready = force_low ? 1'b0 : (req_age >= wait_n);

    always @(posedge clk) begin
        if (reset) begin
            req_age <= 8'd0;
            wr_cnt  <= 8'd0;
            wr_addr <= 16'h0;
            wr_data <= 16'h0;
        end else begin
            if ((readM || writeM) && !mem_ready) req_age <= req_age + 8'd1;
            else                                 req_age <= 8'd0;
            if (writeM && mem_ready) begin
                wr_cnt  <= wr_cnt + 8'd1;
                wr_addr <= address;
                wr_data <= data;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic load_wwd_prog();
        clear_mem();
        mem[0] = 16'h6012;  // LHI r0,0x12
        mem[1] = 16'h5034;  // ORI r0,r0,0x34
        mem[2] = 16'hF01C;  // WWD r0
        mem[3] = 16'hF01D;  // HLT
    endtask

    initial begin
        checks = 0; errors = 0;
        reset = 1'b1; step_mode = 1'b0; step = 1'b0; force_low = 1'b0; wait_n = 8'd0;

        // Zero-wait LHI/ORI/WWD: 11 cycles from first readM to third retire.
        load_wwd_prog();
        reset = 1'b1;
        #1;
        check("rst_readM", {15'd0, readM}, 16'd0);
        check("rst_writeM", {15'd0, writeM}, 16'd0);
        check("rst_num_inst", num_inst, 16'd0);
        check("rst_output", output_port, 16'd0);
        check("rst_halted", {15'd0, is_halted}, 16'd0);
        check("rst_fault", {15'd0, fault}, 16'd0);
        do_reset();
        check("pre_edge_readM", {15'd0, readM}, 16'd0);
        tick();
        check("first_readM", {15'd0, readM}, 16'd1);
        check("first_addr", address, 16'h0000);
        repeat (10) tick();
        check("nowait_num_10", num_inst, 16'd2);
        tick();
        check("nowait_num_11", num_inst, 16'd3);
        check("nowait_output", output_port, 16'h1234);

        // Two wait cycles per fetch: six extra cycles, request held stable.
        wait_n = 8'd2;
        do_reset();
        tick();
        tick();
        check("wait1_readM", {15'd0, readM}, 16'd1);
        check("wait1_addr", address, 16'h0000);
        tick();
        check("wait2_readM", {15'd0, readM}, 16'd1);
        check("wait2_addr", address, 16'h0000);
        repeat (14) tick();
        check("wait_num_16", num_inst, 16'd2);
        tick();
        check("wait_num_17", num_inst, 16'd3);
        check("wait_output", output_port, 16'h1234);
        check("wait_fault", {15'd0, fault}, 16'd0);

        // Ready on the last allowed wait cycle: completion wins over the watchdog.
        wait_n = 8'd3;
        do_reset();
        repeat (5) tick();
        check("edge_fault", {15'd0, fault}, 16'd0);
        check("edge_decode_readM", {15'd0, readM}, 16'd0);
        for (int i = 0; i < 100 && !is_halted; i++) tick();
        check("edge_halted", {15'd0, is_halted}, 16'd1);
        check("edge_output", output_port, 16'h1234);
        check("edge_num", num_inst, 16'd4);

        // Watchdog: mem_ready stuck low during fetch.
        force_low = 1'b1;
        do_reset();
        tick();
        repeat (3) tick();
        check("wd_fault_early", {15'd0, fault}, 16'd0);
        check("wd_readM_early", {15'd0, readM}, 16'd1);
        tick();
        check("wd_fault", {15'd0, fault}, 16'd1);
        check("wd_readM", {15'd0, readM}, 16'd0);
        check("wd_num", num_inst, 16'd0);
        check("wd_pc", address, 16'h0000);
        force_low = 1'b0;
        repeat (3) tick();
        check("wd_sticky", {15'd0, fault}, 16'd1);
        check("wd_sticky_readM", {15'd0, readM}, 16'd0);

        // Illegal opcode faults after DECODE with pc one past it.
        wait_n = 8'd0;
        clear_mem();
        mem[0] = 16'h4101;  // ADI r1,r0,1
        mem[1] = 16'hB000;  // illegal opcode 11
        do_reset();
        for (int i = 0; i < 50 && !fault; i++) tick();
        check("ill_fault", {15'd0, fault}, 16'd1);
        check("ill_num", num_inst, 16'd1);
        check("ill_pc", address, 16'h0002);

        // Store, load back, taken branch skipping two HLTs.
        clear_mem();
        mem[0] = 16'h4105;  // ADI r1,r0,5
        mem[1] = 16'h8140;  // SWD r1,[r0+0x40]
        mem[2] = 16'h7240;  // LWD r2,[r0+0x40]
        mem[3] = 16'h0802;  // BNE r2,r0,+2
        mem[4] = 16'hF01D;
        mem[5] = 16'hF01D;
        mem[6] = 16'hF81C;  // WWD r2
        mem[7] = 16'hF01D;
        do_reset();
        for (int i = 0; i < 50 && !writeM; i++) tick();
        check("st_writeM", {15'd0, writeM}, 16'd1);
        check("st_addr", address, 16'h0040);
        check("st_data", data, 16'h0005);
        check("st_readM", {15'd0, readM}, 16'd0);
        for (int i = 0; i < 100 && !is_halted; i++) tick();
        check("br_halted", {15'd0, is_halted}, 16'd1);
        check("br_output", output_port, 16'h0005);
        check("br_num", num_inst, 16'd6);
        check("st_count", {8'd0, wr_cnt}, 16'd1);
        check("st_mem_addr", wr_addr, 16'h0040);
        check("st_mem_data", wr_data, 16'h0005);

        // Single-step: one instruction per step pulse.
        step_mode = 1'b1;
        clear_mem();
        mem[0] = 16'h4101;  // ADI r1,r0,1
        mem[1] = 16'h4501;  // ADI r1,r1,1
        mem[2] = 16'h4501;
        mem[3] = 16'hF41C;  // WWD r1
        mem[4] = 16'hF01D;  // HLT
        do_reset();
        repeat (8) tick();
        check("step_num_1", num_inst, 16'd1);
        check("step_idle_readM", {15'd0, readM}, 16'd0);
        for (int k = 2; k <= 5; k++) begin
            step = 1'b1;
            tick();
            step = 1'b0;
            repeat (8) tick();
            check("step_num", num_inst, 16'(k));
            check("step_idle", {15'd0, readM}, 16'd0);
        end
        check("step_output", output_port, 16'h0003);
        check("step_halted", {15'd0, is_halted}, 16'd1);
        step_mode = 1'b0;

        // Asynchronous reset while LWD is waiting in MEM.
        wait_n = 8'd3;
        clear_mem();
        mem[0] = 16'h4101;  // ADI r1,r0,1
        mem[1] = 16'h7110;  // LWD r1,[r0+0x10]
        do_reset();
        for (int i = 0; i < 60 && !(readM && address == 16'h0010); i++) tick();
        check("lwd_addr", address, 16'h0010);
        check("lwd_num", num_inst, 16'd1);
        #2;
        reset = 1'b1;
        #1;
        check("arst_readM", {15'd0, readM}, 16'd0);
        check("arst_num", num_inst, 16'd0);
        check("arst_pc", address, 16'h0000);
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick();
        check("restart_readM", {15'd0, readM}, 16'd1);
        check("restart_addr", address, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
